// File: rtl/sdram_aux_arbiter.sv
// sdram_aux_arbiter
//   Round-robin arbiter that lets three auxiliary clients share the SDRAM
//   controller's tape port. Each access runs through ISSUE -> WAIT -> DONE.
//   WAIT ends on a read-ack toggle, on a write-ack pulse, or after TIMEOUT
//   cycles. A timed-out access returns rd_data = 8'hFF with err set.
//
// Parameters
//   TIMEOUT     wait-cycle limit per access (10-bit counter)
// Ports
//   clk, reset  SDRAM system clock; synchronous active-high reset
//   cN_req/we/addr/din   client N request (level), direction, address, data
//   cN_ack      client N completion pulse (one cycle, in DONE)
//   rd_data     read data shared by all clients; err flags a timed-out access
//   mem_addr/mem_din/mem_rd/mem_wr   request side to the controller
//   mem_dout    read data from the controller
//   mem_rd_ack  toggles once per completed read
//   mem_wr_ack  one-cycle pulse per completed write
module sdram_aux_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [22:0] c0_addr,
    input  logic [7:0]  c0_din,
    output logic        c0_ack,
    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [22:0] c1_addr,
    input  logic [7:0]  c1_din,
    output logic        c1_ack,
    input  logic        c2_req,
    input  logic        c2_we,
    input  logic [22:0] c2_addr,
    input  logic [7:0]  c2_din,
    output logic        c2_ack,
    output logic [7:0]  rd_data,
    output logic        err,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_dout,
    input  logic        mem_rd_ack,
    input  logic        mem_wr_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [1:0]  grant, grant_nxt;
    logic        we, we_nxt;
    logic [9:0]  cnt, cnt_nxt;
    logic        rd_ref, rd_ref_nxt;
    logic [2:0]  ack, ack_nxt;
    logic        err_nxt;
    logic [7:0]  rd_data_nxt;
    logic [22:0] mem_addr_nxt;
    logic [7:0]  mem_din_nxt;
    logic        mem_rd_nxt, mem_wr_nxt;

    logic [2:0]  req;
    logic [1:0]  sel;
    logic        sel_found;
    logic        g_we;
    logic [22:0] g_addr;
    logic [7:0]  g_din;

    assign req    = {c2_req, c1_req, c0_req};
    assign c0_ack = ack[0];
    assign c1_ack = ack[1];
    assign c2_ack = ack[2];

    // First requester at or after the round-robin pointer, wrapping 2 -> 0.
    always_comb begin
        int unsigned idx;
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            idx = (32'(ptr) + i) % 32'd3;
            if (!sel_found && req[idx[1:0]]) begin
                sel       = idx[1:0];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        g_we   = c0_we;
        g_addr = c0_addr;
        g_din  = c0_din;
        case (grant)
            2'd1: begin
                g_we   = c1_we;
                g_addr = c1_addr;
                g_din  = c1_din;
            end
            2'd2: begin
                g_we   = c2_we;
                g_addr = c2_addr;
                g_din  = c2_din;
            end
            default: ;
        endcase
    end

    always_comb begin
        logic finish;
        state_nxt    = state;
        ptr_nxt      = ptr;
        grant_nxt    = grant;
        we_nxt       = we;
        cnt_nxt      = cnt;
        rd_ref_nxt   = rd_ref;
        ack_nxt      = '0;
        err_nxt      = 1'b0;
        rd_data_nxt  = rd_data;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        mem_rd_nxt   = mem_rd;
        mem_wr_nxt   = mem_wr;
        finish       = 1'b0;

        case (state)
            IDLE: begin
                // Follow the ack line while idle so toggles seen between
                // accesses cannot be mistaken for the next completion.
                rd_ref_nxt = mem_rd_ack;
                if (sel_found) begin
                    grant_nxt = sel;
                    ptr_nxt   = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr_nxt = g_addr;
                mem_din_nxt  = g_din;
                we_nxt       = g_we;
                mem_rd_nxt   = !g_we;
                mem_wr_nxt   = g_we;
                cnt_nxt      = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + 10'd1;
                // Completion wins over timeout in the last allowed cycle.
                if (!we && (mem_rd_ack != rd_ref)) begin
                    rd_data_nxt = mem_dout;
                    rd_ref_nxt  = mem_rd_ack;
                    finish      = 1'b1;
                end else if (we && mem_wr_ack) begin
                    finish = 1'b1;
                end else if (cnt == TO_LAST) begin
                    rd_data_nxt = 8'hFF;
                    err_nxt     = 1'b1;
                    finish      = 1'b1;
                end
                if (finish) begin
                    mem_rd_nxt = 1'b0;
                    mem_wr_nxt = 1'b0;
                    ack_nxt    = 3'b001 << grant;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            grant    <= '0;
            we       <= 1'b0;
            cnt      <= '0;
            rd_ref   <= mem_rd_ack;
            ack      <= '0;
            err      <= 1'b0;
            rd_data  <= 8'hFF;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            we       <= we_nxt;
            cnt      <= cnt_nxt;
            rd_ref   <= rd_ref_nxt;
            ack      <= ack_nxt;
            err      <= err_nxt;
            rd_data  <= rd_data_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
            mem_rd   <= mem_rd_nxt;
            mem_wr   <= mem_wr_nxt;
        end
    end

endmodule

// File: doc/sdram_aux_arbiter.md
SDRAM_AUX_ARBITER -- requirements
Module: sdram_aux_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, wait-cycle limit per access before abort (10-bit counter).
REQ-002 clk  in  1  SDRAM system clock, same clock as SDRAM controller.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cN_req  in  1  client N (N=0..2) request, level; held high until cN_ack.
REQ-005 cN_we  in  1  client N write (1) / read (0); stable while cN_req high.
REQ-006 cN_addr  in  23  client N byte address; stable while cN_req high.
REQ-007 cN_din  in  8  client N write data; stable while cN_req high.
REQ-008 cN_ack  out  1  client N completion, one-cycle pulse.
REQ-009 rd_data  out  8  read data, shared by all clients; valid with any cN_ack of a read.
REQ-010 err  out  1  high with cN_ack when the access timed out.
REQ-011 mem_addr  out  23  to controller tape_addr.
REQ-012 mem_din  out  8  to controller tape_din.
REQ-013 mem_rd  out  1  to controller tape_rd, level.
REQ-014 mem_wr  out  1  to controller tape_wr, level.
REQ-015 mem_dout  in  8  from controller tape_dout.
REQ-016 mem_rd_ack  in  1  from controller; toggles once per completed read.
REQ-017 mem_wr_ack  in  1  from controller; one-cycle pulse per completed write.

Function
REQ-018 The block SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE: if any cN_req high, the block SHALL grant the first requester at or after the round-robin pointer (order 0,1,2, wrapping) and go to ISSUE; else stay.
REQ-020 On grant, the pointer SHALL become (granted index + 1) mod 3.
REQ-021 ISSUE (1 cycle): latch granted addr/din/we into mem_addr/mem_din; assert mem_rd if read, mem_wr if write; clear the timeout counter; go to WAIT.
REQ-022 WAIT, read: complete when mem_rd_ack differs from the stored reference bit; capture mem_dout into rd_data and update the reference bit in the same cycle.
REQ-023 WAIT, write: complete on the cycle mem_wr_ack is high.
REQ-024 On completion, mem_rd and mem_wr SHALL drop in the same clock edge that leaves WAIT (no duplicate access), state goes to DONE.
REQ-025 WAIT: the counter SHALL increment each cycle; when it reaches TIMEOUT without completion, drop strobes, set rd_data=8'hFF, go to DONE with err flag set.
REQ-026 DONE (1 cycle): pulse cN_ack of the granted client, err as determined; go to IDLE; mem_rd/mem_wr stay low, giving at least 2 low cycles between accesses.
REQ-027 At most one cN_ack SHALL be high in any cycle; mem_rd and mem_wr SHALL never be high together.
REQ-028 Requests arriving while busy SHALL be held (not lost), served in round-robin order after DONE.
REQ-029 A client dropping cN_req before its ack is a protocol violation; the block SHALL still complete the access and pulse cN_ack.
REQ-030 mem_wr_ack seen outside WAIT, and mem_rd_ack toggles outside WAIT, SHALL be ignored except that the reference bit tracks mem_rd_ack in IDLE.
REQ-031 Minimum latency SHALL be cN_req high -> cN_ack pulse = 4 cycles when memory acks the cycle after ISSUE.

Reset
REQ-032 On reset: state IDLE, pointer 0, mem_rd=0, mem_wr=0, all cN_ack=0, err=0, rd_data=8'hFF, mem_addr=0, mem_din=0, counter 0, reference bit loaded from current mem_rd_ack.
REQ-033 Reset during WAIT SHALL abort without any cN_ack; the aborted access is not retried.

Verification
REQ-034 Single read: c1 read addr 0x012345, controller toggles rd_ack 6 cycles later with mem_dout=0xA5 -> c1_ack one pulse, rd_data=0xA5, err=0, mem_rd high exactly 7 cycles.
REQ-035 Contention: c0,c1,c2 requests asserted same cycle, pointer 0 -> grants 0,1,2 in order; then c0,c2 again -> grants 0,2 after pointer 0.
REQ-036 Write: c2 write addr 0x7FFFFF din 0x3C -> mem_addr=0x7FFFFF, mem_din=0x3C, mem_wr drops same edge wr_ack seen, c2_ack one pulse.
REQ-037 Timeout: TIMEOUT=16, no ack -> strobe drops after 16 WAIT cycles, c0_ack with err=1, rd_data=0xFF; late rd_ack toggle afterwards ignored.
REQ-038 Reset mid-WAIT, then new read -> no stale ack, new read completes on its own toggle only.
REQ-039 Back-to-back: c0 held continuously, 10 reads -> 10 acks, mem_rd low >=2 cycles between accesses, no duplicate.
